// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main control FSM of the multicycle CPU. Each instruction is walked through
// fetch, decode, execute, memory and write-back. The outputs are decoded from
// the registered state. The exceptions are pc_write in BRANCH (it follows zero)
// and the enables gated by the memory handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   opcode       IR[31:28], valid from DECODE onward
//   zero         ALU zero flag, consumed in BRANCH
//   mem_ready    memory completes the current read/write this cycle
//   mem_read     memory read request, held until mem_ready
//   mem_write    memory write request, held until mem_ready
//   iord         memory address select (0 = PC, 1 = ALUOut)
//   ir_write     IR load enable
//   pc_write     PC load enable
//   pc_src       PC source (00 = ALU, 01 = ALUOut, 10 = jump target)
//   alu_src_a    ALU A select (0 = PC, 1 = reg A)
//   alu_src_b    ALU B select (00 = reg B, 01 = 1, 10 = sign-extended imm)
//   alu_op       ALU operation code
//   reg_write    register-file write enable
//   reg_dst      destination register (0 = rt, 1 = rd)
//   mem_to_reg   write-back source (0 = ALUOut, 1 = MDR)
//   halted       high while in HALT
//   illegal      sticky: an illegal opcode was decoded
//   state        current state, for debug
//   instr_count  completed fetches, wraps modulo 2^CNT_W
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  state_t           dec_state_s;
  logic             illegal_r;
  logic [CNT_W-1:0] count_r;
  logic             illegal_dec_s;

  // Opcodes 1011..1110 are not defined; they are flagged in DECODE.
  assign illegal_dec_s = (state_r == S_DECODE) && (opcode >= 4'd11) && (opcode <= 4'd14);

  // State register, retired-fetch counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= S_FETCH;
      count_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_FETCH) && mem_ready) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      if (illegal_dec_s) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: next_state_s = S_EXEC_R;
          4'd7, 4'd8: next_state_s = S_MEM_ADDR;
          4'd9:       next_state_s = S_BRANCH;
          4'd10:      next_state_s = S_JUMP;
          default:    next_state_s = S_HALT;   // halt and illegal opcodes
        endcase
      end
      S_EXEC_R: next_state_s = S_WB_R;
      S_WB_R:   next_state_s = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == 4'd7) next_state_s = S_MEM_RD;
        else                next_state_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) next_state_s = S_MEM_WB;
        else           next_state_s = S_MEM_RD;
      end
      S_MEM_WB: next_state_s = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEM_WR;
      end
      S_BRANCH: next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode. While reset_n is low the outputs show the FETCH decode with
  // every enable forced off. This abandons any in-flight transaction and keeps
  // a register or PC write from landing on the reset edge.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    dec_state_s = reset_n ? state_r : S_FETCH;
    case (dec_state_s)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        ir_write  = mem_ready & reset_n;
        pc_write  = mem_ready & reset_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = opcode[2:0];
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b011;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign state       = state_r;
  assign illegal     = illegal_r;
  assign instr_count = count_r;

endmodule
